alu_chain: RTL

//   Multi-cycle sequencer placed directly upstream of the N-bit alu slice.

---
 rtl/alu_chain.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_chain.sv
// Sequencer that runs one K*N-bit operation on an external N-bit alu slice,
// issuing one slice per cycle LSB-first and chaining carry/borrow between slices.
module alu_chain #(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int AC_N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AC_N-1:0] op,
  input  logic [K*N-1:0]  opd_a,
  input  logic [K*N-1:0]  opd_b,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [K*N-1:0]  result,
  output logic            carry,
  output logic            zero,
  output logic [AC_N-1:0] alu_cs,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_cout
);

  localparam int W  = K * N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  // Opcode encoding shared with the alu slice.
  localparam logic [AC_N-1:0] AC_AD  = AC_N'(0);
  localparam logic [AC_N-1:0] AC_SB  = AC_N'(1);
  localparam logic [AC_N-1:0] AC_ADX = AC_N'(2);
  localparam logic [AC_N-1:0] AC_SBX = AC_N'(3);
  localparam logic [AC_N-1:0] AC_LS  = AC_N'(6);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AC_N-1:0] op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cin_q, cin_d;
  logic            cprev_q, cprev_d;
  logic            carry_q, carry_d;
  logic            first, last;
  int              base;

  assign first  = (idx_q == '0);
  assign last   = (idx_q == IW'(K - 1));
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = ~|result_q;

  // Slice issue: operand slices, per-slice opcode and chained carry-in.
  always_comb begin
    base    = int'(idx_q) * N;
    alu_cs  = op_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    if (state_q == S_RUN) begin
      alu_a = a_q[base +: N];
      alu_b = b_q[base +: N];
      case (op_q)
        AC_AD:  alu_cin = first ? cin_q : cprev_q;
        AC_ADX: begin
          alu_cs  = first ? AC_ADX : AC_AD;
          alu_cin = first ? 1'b0 : cprev_q;
        end
        AC_SB:  alu_cin = first ? cin_q : ~cprev_q;
        AC_SBX, AC_LS: begin
          alu_cs  = first ? AC_SBX : AC_SB;
          alu_cin = first ? 1'b0 : ~cprev_q;
        end
        default: alu_cin = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    result_d = result_q;
    cprev_d  = cprev_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          idx_d    = '0;
          op_d     = op;
          a_d      = opd_a;
          b_d      = opd_b;
          cin_d    = cin;
          result_d = '0;
          carry_d  = 1'b0;
          cprev_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[base +: N] = alu_s;
        cprev_d             = alu_cout;
        idx_d               = idx_q + IW'(1);
        if (last) begin
          state_d = S_DONE;
          idx_d   = '0;
          if (op_q == AC_AD || op_q == AC_ADX || op_q == AC_SB || op_q == AC_SBX)
            carry_d = alu_cout;
          // Less-than collapses to the final borrow of a - b.
          if (op_q == AC_LS)
            result_d = {{(W-1){1'b0}}, alu_cout};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      cprev_q  <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      result_q <= result_d;
      cprev_q  <= cprev_d;
      carry_q  <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

endmodule
